// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter slice.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    GAP,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  // Smallest width able to index 'value' distinct items.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, with wrap-around.
module rr_pick
  import uart_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan offsets from the far end down to zero so the nearest requester wins last.
  always_comb begin
    int sum;
    idx = '0;
    any = |req;
    sum = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = int'(ptr) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      if (req[sum[IDX_W-1:0]]) idx = sum[IDX_W-1:0];
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler driving the load/gap/start strobe sequence of a shared UART transmitter.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int  NREQ       = 4,
  parameter int  HOLD_TICKS = 2,
  parameter int  BUSY_TO    = 4,
  localparam int IDX_W      = clog2(NREQ)
) (
  input  logic                   CLOCK_125_p,
  input  logic                   KEY0,
  input  logic                   baud_tick,
  input  logic [NREQ-1:0]        req,
  input  logic [BYTE_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]        ack,
  output logic [BYTE_W-1:0]      tx_data,
  output logic                   tx_load,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic [IDX_W-1:0]       owner,
  output logic                   active,
  output logic                   err
);

  localparam int MAX_LIMIT = (HOLD_TICKS > BUSY_TO) ? HOLD_TICKS : BUSY_TO;
  localparam int CNT_W     = clog2(MAX_LIMIT + 1);

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               hold_done;
  logic               busy_done;
  logic               timeout;
  logic               grant;

  rr_pick #(
    .NREQ (NREQ),
    .IDX_W(IDX_W)
  ) u_pick (
    .req(req),
    .ptr(ptr),
    .idx(pick_idx),
    .any(pick_any)
  );

  // Next-state logic; a limit seen on the counter moves the FSM on the following edge.
  always_comb begin
    next_state = state;
    timeout    = 1'b0;
    hold_done  = (cnt == CNT_W'(HOLD_TICKS));
    busy_done  = (cnt == CNT_W'(BUSY_TO));
    grant      = (state == IDLE) && pick_any;
    case (state)
      IDLE:      if (pick_any) next_state = LOAD;
      LOAD:      if (hold_done) next_state = GAP;
      GAP:       if (hold_done) next_state = START;
      START:     if (hold_done) next_state = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy) begin
          next_state = WAIT_DONE;
        end else if (busy_done) begin
          next_state = IDLE;
          timeout    = 1'b1;
        end
      end
      WAIT_DONE: if (!tx_busy) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLOCK_125_p or negedge KEY0) begin
    if (!KEY0) state <= IDLE;
    else       state <= next_state;
  end

  // Baud tick counter, restarted on every state change and saturating at its maximum.
  always_ff @(posedge CLOCK_125_p or negedge KEY0) begin
    if (!KEY0) begin
      cnt <= '0;
    end else if (next_state != state) begin
      cnt <= '0;
    end else if (baud_tick && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Registered outputs, grant capture and round-robin pointer advance on return to IDLE.
  always_ff @(posedge CLOCK_125_p or negedge KEY0) begin
    if (!KEY0) begin
      ack      <= '0;
      tx_data  <= '0;
      owner    <= '0;
      ptr      <= '0;
      tx_load  <= 1'b0;
      tx_start <= 1'b0;
      active   <= 1'b0;
      err      <= 1'b0;
    end else begin
      ack      <= grant ? (NREQ'(1) << pick_idx) : '0;
      tx_load  <= (next_state == LOAD);
      tx_start <= (next_state == START);
      active   <= (next_state != IDLE);
      err      <= timeout;
      if (grant) begin
        tx_data <= req_data[pick_idx*BYTE_W +: BYTE_W];
        owner   <= pick_idx;
      end
      if ((state != IDLE) && (next_state == IDLE)) begin
        ptr <= (owner == IDX_W'(NREQ - 1)) ? '0 : owner + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: transaction-level model of grant order and strobe/tick timing.
module tb_uart_tx_arbiter;

  localparam int NREQ       = 4;
  localparam int HOLD_TICKS = 2;
  localparam int BUSY_TO    = 4;

  logic                CLOCK_125_p;
  logic                KEY0;
  logic                baud_tick;
  logic [NREQ-1:0]     req;
  logic [8*NREQ-1:0]   req_data;
  logic [NREQ-1:0]     ack;
  logic [7:0]          tx_data;
  logic                tx_load;
  logic                tx_start;
  logic                tx_busy;
  logic [1:0]          owner;
  logic                active;
  logic                err;

  int checks = 0;
  int errors = 0;
  int ptrModel = 0;
  int cyc = 0;
  bit tickEn = 1'b1;

  uart_tx_arbiter #(
    .NREQ      (NREQ),
    .HOLD_TICKS(HOLD_TICKS),
    .BUSY_TO   (BUSY_TO)
  ) dut (
    .CLOCK_125_p(CLOCK_125_p),
    .KEY0       (KEY0),
    .baud_tick  (baud_tick),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .tx_data    (tx_data),
    .tx_load    (tx_load),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .owner      (owner),
    .active     (active),
    .err        (err)
  );

  // 125 MHz system clock.
  initial begin
    CLOCK_125_p = 1'b0;
    forever #4 CLOCK_125_p = ~CLOCK_125_p;
  end

  // One baud tick every 8 clocks unless stalled.
  initial begin
    baud_tick = 1'b0;
    forever begin
      @(posedge CLOCK_125_p);
      #1;
      cyc++;
      baud_tick = tickEn && (cyc % 8 == 0);
    end
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "[TB] time limit");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Spec rule: first requester at or after ptr, searching with wrap-around.
  function automatic int pickModel(input logic [NREQ-1:0] r, input int p);
    for (int off = 0; off < NREQ; off++) begin
      if (r[(p + off) % NREQ]) return (p + off) % NREQ;
    end
    return 0;
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ack"}, ack, 0);
    checkOutput({tag, "_tx_data"}, tx_data, 0);
    checkOutput({tag, "_tx_load"}, tx_load, 0);
    checkOutput({tag, "_tx_start"}, tx_start, 0);
    checkOutput({tag, "_owner"}, owner, 0);
    checkOutput({tag, "_active"}, active, 0);
    checkOutput({tag, "_err"}, err, 0);
  endtask

  // Runs one transfer from the grant onward; call at a negedge with req already applied.
  // tmo: transmitter never raises busy. bdelay: ticks into WAIT_BUSY before busy rises (-1 = during START).
  task automatic applyStimulus(input bit tmo, input int bdelay, input int blen, input bit late,
                               input bit stall, input bit rstStart,
                               output int gotOwner, output int gotByte);
    int   expOwner;
    logic [7:0] expByte;
    int   phase, ticks, bticks, budget;
    bit   done, first;
    expOwner = pickModel(req, ptrModel);
    expByte  = req_data[expOwner*8 +: 8];
    @(negedge CLOCK_125_p);
    checkOutput("grant_ack", ack, 1 << expOwner);
    checkOutput("grant_owner", owner, expOwner);
    checkOutput("grant_tx_data", tx_data, expByte);
    checkOutput("grant_tx_load", tx_load, 1);
    checkOutput("grant_tx_start", tx_start, 0);
    checkOutput("grant_active", active, 1);
    checkOutput("grant_err", err, 0);
    gotOwner = int'(owner);
    gotByte  = int'(tx_data);
    if (late) begin
      req_data = $urandom();
      req      = NREQ'($urandom());
    end
    phase = 0; ticks = 0; bticks = 0; budget = 3000; done = 1'b0; first = 1'b1;
    if (stall) begin
      ticks += int'(baud_tick);
      tickEn = 1'b0;
      repeat (100) begin
        @(negedge CLOCK_125_p);
        checkOutput("stall_tx_load", tx_load, 1);
      end
      tickEn = 1'b1;
      first  = 1'b0;
      @(negedge CLOCK_125_p);
    end
    while (!done) begin
      checkOutput("no_overlap", tx_load & tx_start, 0);
      if (!first) checkOutput("ack_one_cycle", ack, 0);
      if (phase < 5 && !err) begin
        checkOutput("hold_tx_data", tx_data, expByte);
        checkOutput("hold_owner", owner, expOwner);
      end
      if (phase == 0 && !tx_load) begin
        checkOutput("load_ticks", ticks, HOLD_TICKS);
        phase = 1; ticks = 0;
      end
      if (phase == 1 && tx_start) begin
        checkOutput("gap_ticks", ticks, HOLD_TICKS);
        phase = 2; ticks = 0;
        if (rstStart) begin
          #2 KEY0 = 1'b0;
          #1;
          checkAllZero("rst_async");
          @(negedge CLOCK_125_p);
          checkAllZero("rst_hold");
          KEY0     = 1'b1;
          tx_busy  = 1'b0;
          ptrModel = 0;
          return;
        end
        if (!tmo && bdelay < 0) tx_busy = 1'b1;
      end
      if (phase == 2 && !tx_start) begin
        checkOutput("start_ticks", ticks, HOLD_TICKS);
        phase = 3; ticks = 0;
      end
      if (phase < 3) begin
        ticks += int'(baud_tick);
      end else if (phase == 3) begin
        if (tmo) begin
          if (err) begin
            checkOutput("timeout_ticks", ticks, BUSY_TO);
            checkOutput("timeout_active", active, 0);
            done = 1'b1;
          end else begin
            checkOutput("wait_active", active, 1);
            ticks += int'(baud_tick);
          end
        end else begin
          checkOutput("wait_err", err, 0);
          checkOutput("wait_active", active, 1);
          if (tx_busy || ticks >= bdelay) begin
            tx_busy = 1'b1;
            phase = 4; bticks = 0;
          end else begin
            ticks += int'(baud_tick);
          end
        end
      end else if (phase == 4) begin
        checkOutput("busy_err", err, 0);
        checkOutput("busy_active", active, 1);
        if (bticks >= blen) begin
          tx_busy = 1'b0;
          phase = 5;
        end else begin
          bticks += int'(baud_tick);
        end
      end else begin
        checkOutput("done_active", active, 0);
        checkOutput("done_err", err, 0);
        done = 1'b1;
      end
      first = 1'b0;
      budget--;
      if (budget == 0) begin
        checkOutput("walk_budget", 0, 1);
        done = 1'b1;
      end
      if (!done) @(negedge CLOCK_125_p);
    end
    ptrModel = (expOwner + 1) % NREQ;
  endtask

  initial begin
    int gotOwner, gotByte;
    int order[5]  = '{0, 1, 2, 3, 0};
    int bytes[5]  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    KEY0 = 1'b0; req = '0; req_data = '0; tx_busy = 1'b0;
    repeat (3) @(negedge CLOCK_125_p);
    checkAllZero("reset");
    KEY0 = 1'b1;
    @(negedge CLOCK_125_p);
    checkOutput("idle_active", active, 0);
    checkOutput("idle_ack", ack, 0);

    $display("[TB] contention: all four requesters held high");
    req = 4'b1111; req_data = 32'h13121110;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1, 2, 1'b0, 1'b0, 1'b0, gotOwner, gotByte);
      checkOutput("rr_order", gotOwner, order[k]);
      checkOutput("rr_bytes", gotByte, bytes[k]);
    end

    $display("[TB] single request from requester 1");
    req = 4'b0010; req_data = 32'h0000B300;
    applyStimulus(1'b0, 1, 10, 1'b0, 1'b0, 1'b0, gotOwner, gotByte);
    checkOutput("single_owner", gotOwner, 1);
    checkOutput("single_byte", gotByte, 8'hB3);

    $display("[TB] busy timeout");
    req = 4'b0100; req_data = 32'h00A50000;
    applyStimulus(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, gotOwner, gotByte);
    checkOutput("tmo_owner", gotOwner, 2);
    req = 4'b1111; req_data = 32'h44332211;
    applyStimulus(1'b0, 0, 1, 1'b0, 1'b0, 1'b0, gotOwner, gotByte);
    checkOutput("tmo_next_owner", gotOwner, 3);

    $display("[TB] reset during START");
    applyStimulus(1'b0, 0, 1, 1'b0, 1'b0, 1'b0, gotOwner, gotByte);
    applyStimulus(1'b0, 0, 1, 1'b0, 1'b0, 1'b1, gotOwner, gotByte);
    checkOutput("rst_victim_owner", gotOwner, 1);
    applyStimulus(1'b0, 0, 1, 1'b0, 1'b0, 1'b0, gotOwner, gotByte);
    checkOutput("rst_first_owner", gotOwner, 0);

    $display("[TB] late data change and stalled ticks");
    req = 4'b0001; req_data = 32'h000000C7;
    applyStimulus(1'b0, 2, 3, 1'b1, 1'b0, 1'b0, gotOwner, gotByte);
    req = 4'b1000; req_data = 32'h5A000000;
    applyStimulus(1'b0, -1, 0, 1'b0, 1'b1, 1'b0, gotOwner, gotByte);
    checkOutput("stall_owner", gotOwner, 3);

    $display("[TB] randomized transfers");
    for (int n = 0; n < 20; n++) begin
      req      = NREQ'($urandom_range(1, 15));
      req_data = $urandom();
      applyStimulus(($urandom_range(0, 4) == 0), int'($urandom_range(0, 4)) - 1,
                    int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)), 1'b0, 1'b0,
                    gotOwner, gotByte);
    end
    req = '0;
    repeat (4) @(negedge CLOCK_125_p);
    checkOutput("final_idle_active", active, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
